alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the team's 8-bit registered ALU: WIDTH-bit operands, a two-stage valid/ready pipeline with backpressure, and carry, zero and overflow flags. It keeps the existing 5-bit `Sel` encoding, so upstream sequencers drive it unchanged. It sits between the operand-fetch logic and the result writeback path. The upstream producer must be synchronous to `clk`; this block has no CDC synchronizer.

## Interface
- `WIDTH`, default 8: operand and result width, must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block can accept a beat.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `Sel` in 5: operation select.
- `CarryIn` in 1: carry input.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `Y` out WIDTH: result.
- `CarryOut` out 1: carry or shifted-out bit.
- `Zero` out 1: high when `Y` is all zeros.
- `Overflow` out 1: signed overflow, arithmetic operations only.

## Operation
- Accept rule: a beat is accepted when `in_valid && in_ready`.
  - Stage 1 (S1) captures `A`, `B`, `Sel` and `CarryIn`.
  - Stage 2 (S2) computes from S1 and registers `Y` and the flags.
- `Sel[4:3]=00`, `Sel[2]=1` (arithmetic):
  - `[1:0]=00` Y=A; `01` Y=A+B+CarryIn; `10` Y=A+B; `11` Y=B.
  - Sums are computed at WIDTH+1 bits. CarryOut = bit WIDTH of the sum.
  - Overflow = (A[msb]==B[msb]) && (Y[msb]!=A[msb]).
  - For the transfer operations, CarryOut and Overflow are 0.
- `Sel[4:3]=00`, `Sel[2]=0` (logic): `00` AND, `01` OR, `10` XOR, `11` ~A, all using the same beat's A. CarryOut=0, Overflow=0.
- `Sel[4:3]=01`: Y = A<<1, CarryOut = A[WIDTH-1].
- `Sel[4:3]=10`: Y = A>>1 (logical), CarryOut = A[0].
- `Sel[4:3]=11`: Y=0, CarryOut=0.
- Overflow is 0 for every non-arithmetic operation.
- Zero is computed from the final Y for every operation.
- No operation produces X. All `Sel` codes are defined.

## Timing
- Reset values: `out_valid`=0, `Y`=0, `CarryOut`=0, `Zero`=0, `Overflow`=0. S1 and S2 valid bits are 0.
- Latency: a beat accepted at edge N has `out_valid`=1 after edge N+1, provided S2 was free.
- Throughput: one beat per cycle while `out_ready`=1.
- Advance rules:
  - S2 loads when S1 is valid and (!S2 valid or `out_ready`).
  - S1 loads when `in_valid` and `in_ready`.
  - `in_ready` = !S1 valid, or S1 advancing this cycle.
- Hold rule: while `out_valid && !out_ready`, Y and all flags are stable. A full S1 holds and `in_ready`=0.
- Simultaneous pop and push: when a result is popped, S1 moves to S2 and a new beat enters S1 in the same cycle, with no bubble.
- Reset mid-operation: in-flight beats are discarded. The first beat accepted after deassertion behaves as after power-up.
- `in_ready` is combinational from `out_ready`. There is no combinational path from `in_valid` to `out_valid`.

## Configuration
- `ALU_ROTATE_EN` defined: for `Sel[4:3]=01/10` with `Sel[2]=1`, the shift becomes a rotate.
  - Left rotate: Y = {A[WIDTH-2:0], A[WIDTH-1]}.
  - Right rotate: Y = {A[0], A[WIDTH-1:1]}.
  - CarryOut is the same rotated bit.
- Not defined: `Sel[2]` is ignored for shift operations and the logical shifts apply.

## Structure
- Package `alu_pkg` holds:
  - group codes `GRP_ARITH_LOGIC`, `GRP_SHL`, `GRP_SHR`, `GRP_ZERO`;
  - arithmetic codes `OP_TRA`, `OP_ADDC`, `OP_ADD`, `OP_TRB`;
  - logic codes `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NOTA`;
  - a packed `alu_flags_t` struct {carry, zero, ovf}.
- Sub-module `alu_core`: purely combinational WIDTH-parametrised compute of Y and flags from S1 contents. `alu_pipe` owns the handshake and pipeline registers.

## Test plan
- WIDTH=8, A=8'hF0, B=8'h20, Sel=5'b00101, CarryIn=1 → Y=8'h11, CarryOut=1, Overflow=0, Zero=0, `out_valid` one edge after acceptance.
- A=8'h7F, B=8'h01, Sel=5'b00110 → Y=8'h80, Overflow=1, CarryOut=0. Then A=8'hAA, Sel=5'b00011 → Y=8'h55.
- A=8'h81, Sel=5'b01000 → Y=8'h02, CarryOut=1. With `ALU_ROTATE_EN` and Sel=5'b01100 → Y=8'h03, CarryOut=1.
- Stream 4 back-to-back beats with `out_ready` low for 3 cycles:
  - `in_ready` drops after 2 beats are held;
  - the held Y is stable;
  - all 4 results emerge in order with no loss or duplication.
- Assert `rst` with both stages full → `out_valid`, Y and flags are 0 immediately (asynchronous), and `in_ready`=1 after release.
- WIDTH=16, A=16'hFFFF, B=16'h0001, Sel=5'b00110 → Y=16'h0000, Zero=1, CarryOut=1.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_pkg                                                          |
// | Purpose : Shared Sel field codes and the flag bundle for alu_pipe.         |
// |           Optional feature macro used by this block: ALU_ROTATE_EN.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package alu_pkg;

   // Sel[4:3] operation groups
   localparam logic [1:0] GRP_ARITH_LOGIC = 2'b00;
   localparam logic [1:0] GRP_SHL         = 2'b01;
   localparam logic [1:0] GRP_SHR         = 2'b10;
   localparam logic [1:0] GRP_ZERO        = 2'b11;

   // Sel[1:0] when Sel[4:2] = 001 (arithmetic)
   localparam logic [1:0] OP_TRA  = 2'b00;
   localparam logic [1:0] OP_ADDC = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_TRB  = 2'b11;

   // Sel[1:0] when Sel[4:2] = 000 (logic)
   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NOTA = 2'b11;

   typedef struct packed {
      logic carry;
      logic zero;
      logic ovf;
   } alu_flags_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_pipe_if                                                      |
// | Purpose : Operand-in / result-out handshake bundle of alu_pipe.            |
// |           master = producer/consumer side, slave = the ALU pipeline.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [4:0]       Sel;
   logic             CarryIn;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Y;
   logic             CarryOut;
   logic             Zero;
   logic             Overflow;

   modport master (
      output in_valid, A, B, Sel, CarryIn, out_ready,
      input  in_ready, out_valid, Y, CarryOut, Zero, Overflow
   );

   modport slave (
      input  in_valid, A, B, Sel, CarryIn, out_ready,
      output in_ready, out_valid, Y, CarryOut, Zero, Overflow
   );
endinterface : alu_pipe_if
`default_nettype wire

// File: rtl/alu_pipe_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_core                                                         |
// | Purpose : Combinational WIDTH-bit ALU: result plus carry/zero/overflow.    |
// |           ALU_ROTATE_EN: Sel[2]=1 turns the shift groups into rotates.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [4:0]       sel_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] y_o,
   output alu_flags_t       flags_o
);
   logic [WIDTH:0]   sum;
   logic             add_cin;
   logic             rot;
   logic [WIDTH-1:0] y;
   logic             carry;
   logic             ovf;

   // Only ADDC consumes CarryIn; the sum is one bit wider to expose the carry
   always_comb begin
      add_cin = (sel_i[1:0] == OP_ADDC) ? cin_i : 1'b0;
      sum     = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, add_cin};
   end

`ifdef ALU_ROTATE_EN
   assign rot = sel_i[2];
`else
   assign rot = 1'b0;
`endif

   // Result and carry/overflow selection; every Sel code yields a defined value
   always_comb begin
      y     = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (sel_i[4:3])
         GRP_ARITH_LOGIC: begin
            if (sel_i[2]) begin
               case (sel_i[1:0])
                  OP_TRA: y = a_i;
                  OP_TRB: y = b_i;
                  default: begin
                     y     = sum[WIDTH-1:0];
                     carry = sum[WIDTH];
                     ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                             (sum[WIDTH-1] != a_i[WIDTH-1]);
                  end
               endcase
            end else begin
               case (sel_i[1:0])
                  OP_AND:  y = a_i & b_i;
                  OP_OR:   y = a_i | b_i;
                  OP_XOR:  y = a_i ^ b_i;
                  default: y = ~a_i;
               endcase
            end
         end
         GRP_SHL: begin
            y     = {a_i[WIDTH-2:0], rot ? a_i[WIDTH-1] : 1'b0};
            carry = a_i[WIDTH-1];
         end
         GRP_SHR: begin
            y     = {rot ? a_i[0] : 1'b0, a_i[WIDTH-1:1]};
            carry = a_i[0];
         end
         default: begin
            y     = '0;
            carry = 1'b0;
         end
      endcase
   end

   assign y_o           = y;
   assign flags_o.carry = carry;
   assign flags_o.zero  = ~|y;
   assign flags_o.ovf   = ovf;

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_pipe                                                         |
// | Purpose : Two-stage valid/ready ALU pipeline with backpressure.            |
// |           S1 holds the operand beat, S2 holds the registered result.       |
// |           ALU_ROTATE_EN: enables rotate variants in alu_core.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   alu_pipe_if.slave  bus
);
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   logic [4:0]       s1_sel_q;
   logic             s1_cin_q;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_y_q;
   alu_flags_t       s2_flags_q;

   logic             s1_load;
   logic             s2_load;
   logic             in_ready;
   logic [WIDTH-1:0] core_y;
   alu_flags_t       core_flags;

   // Handshake: S2 drains on pop, S1 frees when it hands its beat to S2
   always_comb begin
      s2_load    = s1_valid_q && (!s2_valid_q || bus.out_ready);
      in_ready   = !s1_valid_q || s2_load;
      s1_load    = bus.in_valid && in_ready;
      s1_valid_d = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
      s2_valid_d = s2_load ? 1'b1 : (bus.out_ready ? 1'b0 : s2_valid_q);
   end

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a_i     (s1_a_q),
      .b_i     (s1_b_q),
      .sel_i   (s1_sel_q),
      .cin_i   (s1_cin_q),
      .y_o     (core_y),
      .flags_o (core_flags)
   );

   // Stage 1: capture the operand beat on acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_sel_q   <= '0;
         s1_cin_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s1_load) begin
            s1_a_q   <= bus.A;
            s1_b_q   <= bus.B;
            s1_sel_q <= bus.Sel;
            s1_cin_q <= bus.CarryIn;
         end
      end
   end

   // Stage 2: register result and flags; they only change on a load, so held output is stable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_y_q     <= '0;
         s2_flags_q <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s2_load) begin
            s2_y_q     <= core_y;
            s2_flags_q <= core_flags;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.Y         = s2_y_q;
   assign bus.CarryOut  = s2_flags_q.carry;
   assign bus.Zero      = s2_flags_q.zero;
   assign bus.Overflow  = s2_flags_q.ovf;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_pipe                                                      |
// | Purpose : Self-checking bench for alu_pipe (WIDTH=8 and WIDTH=16).         |
// |           Honours ALU_ROTATE_EN in its reference model.                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_pipe;

   typedef struct packed {
      logic [15:0] y;
      logic        c;
      logic        z;
      logic        v;
   } res_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [4:0] sel;
      logic       cin;
      logic [7:0] y;
      logic       c;
      logic       z;
      logic       v;
   } vec_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [4:0] sel;
      logic       cin;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(8))  bus8 ();
   alu_pipe_if #(.WIDTH(16)) bus16 ();

   alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
   alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   // Reference: plain integer arithmetic on the operation rules
   function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [4:0] sel, input logic cin, input int w);
      res_t r;
      int   full = 1 << w;
      int   half = 1 << (w - 1);
      int   av   = int'(a) % full;
      int   bv   = int'(b) % full;
      int   ci, s, sa, sb, ss;
      int   y    = 0;
      bit   c    = 0;
      bit   v    = 0;
      bit   rot  = 0;
`ifdef ALU_ROTATE_EN
      rot = sel[2];
`endif
      case (sel[4:3])
         2'd0: begin
            if (sel[2]) begin
               case (sel[1:0])
                  2'd0: y = av;
                  2'd3: y = bv;
                  default: begin
                     ci = (sel[1:0] == 2'd1 && cin) ? 1 : 0;
                     s  = av + bv + ci;
                     y  = s % full;
                     c  = (s >= full);
                     sa = (av >= half) ? av - full : av;
                     sb = (bv >= half) ? bv - full : bv;
                     ss = sa + sb + ci;
                     v  = (ss > half - 1) || (ss < -half);
                  end
               endcase
            end else begin
               case (sel[1:0])
                  2'd0: y = av & bv;
                  2'd1: y = av | bv;
                  2'd2: y = av ^ bv;
                  default: y = (full - 1) - av;
               endcase
            end
         end
         2'd1: begin
            c = (av >= half);
            y = (av * 2) % full + ((rot && c) ? 1 : 0);
         end
         2'd2: begin
            c = (av % 2) == 1;
            y = av / 2 + ((rot && c) ? half : 0);
         end
         default: y = 0;
      endcase
      r.y = y[15:0];
      r.c = c;
      r.z = (y == 0);
      r.v = v;
      return r;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive8(input beat_t bt);
      bus8.A       = bt.a;
      bus8.B       = bt.b;
      bus8.Sel     = bt.sel;
      bus8.CarryIn = bt.cin;
   endtask

   // One isolated beat: accept, check one-edge latency, check result
   task automatic apply_one(input vec_t t, input int idx);
      beat_t bt;
      bt = '{t.a, t.b, t.sel, t.cin};
      drive8(bt);
      bus8.in_valid  = 1'b1;
      bus8.out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", idx), 16'(bus8.in_ready), 16'd1);
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      chk($sformatf("v%0d_early_valid", idx), 16'(bus8.out_valid), 16'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", idx), 16'(bus8.out_valid), 16'd1);
      chk($sformatf("v%0d_Y", idx), 16'(bus8.Y), 16'(t.y));
      chk($sformatf("v%0d_CarryOut", idx), 16'(bus8.CarryOut), 16'(t.c));
      chk($sformatf("v%0d_Zero", idx), 16'(bus8.Zero), 16'(t.z));
      chk($sformatf("v%0d_Overflow", idx), 16'(bus8.Overflow), 16'(t.v));
      @(posedge clk); #1;
   endtask

   // Streaming run: mode 0 = out_ready low for 3 cycles then high, mode 1 = random
   task automatic stream(input beat_t src[$], input int mode);
      res_t       exp_q[$];
      res_t       e;
      int         n = src.size();
      int         idx = 0;
      int         got = 0;
      int         cyc = 0;
      bit         hold_prev = 0;
      logic [10:0] prev = '0;
      while (got < n && cyc < n * 20 + 50) begin
         if (idx < n && (mode == 0 || $urandom_range(0, 4) != 0)) begin
            drive8(src[idx]);
            bus8.in_valid = 1'b1;
         end else begin
            bus8.in_valid = 1'b0;
         end
         bus8.out_ready = (mode == 0) ? (cyc >= 3) : ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (hold_prev) begin
            chk("hold_valid", 16'(bus8.out_valid), 16'd1);
            chk("hold_result", 16'({bus8.Y, bus8.CarryOut, bus8.Zero, bus8.Overflow}), 16'(prev));
         end
         if (mode == 0 && cyc == 2)
            chk("in_ready_drop", 16'(bus8.in_ready), 16'd0);
         if (bus8.out_valid && bus8.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_result", 16'(bus8.out_valid), 16'd0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("s%0d_Y", got), 16'(bus8.Y), e.y);
               chk($sformatf("s%0d_flags", got),
                   16'({bus8.CarryOut, bus8.Zero, bus8.Overflow}), 16'({e.c, e.z, e.v}));
            end
            got++;
         end
         hold_prev = bus8.out_valid && !bus8.out_ready;
         prev      = {bus8.Y, bus8.CarryOut, bus8.Zero, bus8.Overflow};
         if (bus8.in_valid && bus8.in_ready) begin
            exp_q.push_back(model({8'h0, src[idx].a}, {8'h0, src[idx].b},
                                  src[idx].sel, src[idx].cin, 8));
            idx++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus8.in_valid = 1'b0;
      chk("stream_complete", 16'(got), 16'(n));
   endtask

   vec_t  tbl[16];
   beat_t bq[$];
   res_t  r16;

   initial begin
      logic [7:0] rot_l;
      logic [7:0] rot_r;
`ifdef ALU_ROTATE_EN
      rot_l = 8'h03;
      rot_r = 8'hC0;
`else
      rot_l = 8'h02;
      rot_r = 8'h40;
`endif
      //          a      b      sel       cin   y      c     z     v
      tbl[0]  = '{8'hF0, 8'h20, 5'b00101, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{8'h7F, 8'h01, 5'b00110, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{8'hAA, 8'h00, 5'b00011, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{8'h81, 8'h00, 5'b01000, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{8'h81, 8'h00, 5'b01100, 1'b0, rot_l, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{8'h81, 8'h00, 5'b10000, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{8'h81, 8'h00, 5'b10100, 1'b0, rot_r, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{8'hF0, 8'h3C, 5'b00000, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{8'hF0, 8'h0F, 5'b00001, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{8'hFF, 8'h0F, 5'b00010, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{8'h5A, 8'hC3, 5'b00100, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{8'h5A, 8'hC3, 5'b00111, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{8'hFF, 8'h01, 5'b00110, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{8'h80, 8'h80, 5'b00101, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
      tbl[14] = '{8'h3C, 8'hFF, 5'b11000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{8'h7F, 8'h00, 5'b00101, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};

      bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;
      bus8.A = '0; bus8.B = '0; bus8.Sel = '0; bus8.CarryIn = 1'b0;
      bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
      bus16.A = '0; bus16.B = '0; bus16.Sel = '0; bus16.CarryIn = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 16'(bus8.out_valid), 16'd0);
      chk("rst_Y", 16'(bus8.Y), 16'd0);
      chk("rst_flags", 16'({bus8.CarryOut, bus8.Zero, bus8.Overflow}), 16'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 16'(bus8.in_ready), 16'd1);
      @(posedge clk); #1;

      // Table vectors
      for (int i = 0; i < 16; i++) apply_one(tbl[i], i);

      // Asynchronous reset with both stages full
      bus8.out_ready = 1'b0;
      drive8('{8'h55, 8'h00, 5'b00100, 1'b0});
      bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      drive8('{8'h0F, 8'h00, 5'b00100, 1'b0});
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      chk("full_out_valid", 16'(bus8.out_valid), 16'd1);
      chk("full_in_ready", 16'(bus8.in_ready), 16'd0);
      chk("full_Y", 16'(bus8.Y), 16'h0055);
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 16'(bus8.out_valid), 16'd0);
      chk("async_rst_Y", 16'(bus8.Y), 16'd0);
      chk("async_rst_flags", 16'({bus8.CarryOut, bus8.Zero, bus8.Overflow}), 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus8.out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 16'(bus8.in_ready), 16'd1);
      @(posedge clk); #1;
      chk("post_rst_no_stale", 16'(bus8.out_valid), 16'd0);
      apply_one(tbl[0], 100);

      // Backpressure: 4 back-to-back beats, out_ready low for 3 cycles
      bq.delete();
      bq.push_back('{8'h10, 8'h20, 5'b00110, 1'b0});
      bq.push_back('{8'hC3, 8'h00, 5'b00011, 1'b0});
      bq.push_back('{8'h81, 8'h00, 5'b10000, 1'b0});
      bq.push_back('{8'h7F, 8'h7F, 5'b00101, 1'b1});
      stream(bq, 0);

      // Randomized stream with random bubbles and backpressure
      bq.delete();
      for (int i = 0; i < 200; i++)
         bq.push_back('{8'($urandom), 8'($urandom), 5'($urandom), 1'($urandom)});
      stream(bq, 1);

      // WIDTH=16 instance: carry/zero boundary, then random single beats
      for (int i = 0; i < 13; i++) begin
         if (i == 0) begin
            bus16.A = 16'hFFFF; bus16.B = 16'h0001; bus16.Sel = 5'b00110; bus16.CarryIn = 1'b0;
         end else begin
            bus16.A = 16'($urandom); bus16.B = 16'($urandom);
            bus16.Sel = 5'($urandom); bus16.CarryIn = 1'($urandom);
         end
         r16 = model(bus16.A, bus16.B, bus16.Sel, bus16.CarryIn, 16);
         bus16.in_valid = 1'b1;
         @(posedge clk); #1;
         bus16.in_valid = 1'b0;
         @(posedge clk); #1;
         if (i == 0) begin
            chk("w16_Y", bus16.Y, 16'h0000);
            chk("w16_flags", 16'({bus16.CarryOut, bus16.Zero, bus16.Overflow}), 16'b110);
         end else begin
            chk($sformatf("w16_%0d_Y", i), bus16.Y, r16.y);
            chk($sformatf("w16_%0d_flags", i),
                16'({bus16.CarryOut, bus16.Zero, bus16.Overflow}), 16'({r16.c, r16.z, r16.v}));
         end
         chk($sformatf("w16_%0d_valid", i), 16'(bus16.out_valid), 16'd1);
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_alu_pipe
`default_nettype wire
